// File: rtl/text_tile_writer_pkg.sv
// Shared definitions for the tile text writer: opcodes, FSM states,
// tile geometry, ASCII constants and message ids.
package text_tile_writer_pkg;

  localparam int unsigned TILE_COLS = 40;
  localparam int unsigned TILE_ROWS = 15;
  localparam int unsigned MSG_MAX   = 24;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_PUT_CHAR  = 3'd1,
    OP_PUT_DIGIT = 3'd2,
    OP_PUT_STR   = 3'd3,
    OP_CLEAR     = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUT,
    S_STR_FETCH,
    S_STR_WAIT,
    S_STR_WR,
    S_CLR,
    S_FIN
  } state_e;

  localparam logic [6:0] ASCII_DIGIT0 = 7'h30;
  localparam logic [6:0] ASCII_QMARK  = 7'h3F;
  localparam logic [6:0] ASCII_BLANK  = 7'h00;

  localparam logic [1:0] MSG_PONG        = 2'd0;
  localparam logic [1:0] MSG_PRESS_START = 2'd1;
  localparam logic [1:0] MSG_P1_WINS     = 2'd2;
  localparam logic [1:0] MSG_P2_WINS     = 2'd3;

  // Tile RAM address is {row, col}; columns 40..63 of each row are unused.
  function automatic logic [9:0] tile_addr(input logic [3:0] row, input logic [5:0] col);
    return {row, col};
  endfunction

  function automatic logic [6:0] digit_char(input logic [3:0] v);
    return (v <= 4'd9) ? ASCII_DIGIT0 + {3'b000, v} : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/text_msg_rom.sv
// Fixed message strings, 0x00-terminated, synchronous 1-cycle read.
module text_msg_rom
  import text_tile_writer_pkg::*;
(
  input  logic       CLK,
  input  logic [6:0] addr,
  output logic [6:0] data
);

  localparam logic [191:0] STR_PONG  = 192'("PONG");
  localparam logic [191:0] STR_PRESS = 192'("PRESS SW3 TO START");
  localparam logic [191:0] STR_P1    = 192'("P1 WINS");
  localparam logic [191:0] STR_P2    = 192'("P2 WINS");

  // Strings are right-aligned in the vector, so character i of a string of
  // length len sits at byte len-1-i; anything past the end reads as 0x00.
  function automatic logic [6:0] pick(input logic [191:0] s, input int unsigned len,
                                      input logic [4:0] i);
    logic [7:0] base;
    if ({27'd0, i} >= len) return ASCII_BLANK;
    base = 8'(8 * (len - 1 - {27'd0, i}));
    return s[base +: 7];
  endfunction

  // Registered read, same access style as the font ROM.
  always_ff @(posedge CLK) begin
    case (addr[6:5])
      MSG_PONG:        data <= pick(STR_PONG,  4,  addr[4:0]);
      MSG_PRESS_START: data <= pick(STR_PRESS, 18, addr[4:0]);
      MSG_P1_WINS:     data <= pick(STR_P1,    7,  addr[4:0]);
      default:         data <= pick(STR_P2,    7,  addr[4:0]);
    endcase
  end

endmodule

// File: rtl/text_tile_writer.sv
// Command-driven writer into the 40x15 character tile RAM: single chars,
// score digits, ROM message strings and full-screen clear.
module text_tile_writer
  import text_tile_writer_pkg::*;
#(
  parameter int unsigned COLS        = TILE_COLS,
  parameter int unsigned ROWS        = TILE_ROWS,
  parameter int unsigned MAX_STR     = MSG_MAX,
  parameter bit          VBLANK_ONLY = 1'b0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_row,
  input  logic [5:0] cmd_col,
  input  logic [6:0] cmd_data,
  input  logic       vblank,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [6:0] wr_data,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] COL_LAST  = 6'(COLS - 1);
  localparam logic [3:0] ROW_LAST  = 4'(ROWS - 1);
  localparam logic [4:0] IDX_LIMIT = 5'(MAX_STR);

  state_e     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [5:0] col_q, col_d;
  logic [6:0] char_q, char_d;
  logic [1:0] msg_id_q, msg_id_d;
  logic [4:0] idx_q, idx_d;
  logic       wr_en_q, wr_en_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [6:0] wr_data_q, wr_data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       gate;
  logic [3:0] start_row, next_row;
  logic [5:0] start_col, next_col;
  logic [6:0] rom_data;

  assign gate = ~VBLANK_ONLY | vblank;

  text_msg_rom u_rom (
    .CLK  (CLK),
    .addr ({msg_id_q, idx_q}),
    .data (rom_data)
  );

  // Clamp start coordinates and compute the raster-order cursor successor.
  always_comb begin
    start_row = (cmd_row >= ROW_LAST) ? ROW_LAST : cmd_row;
    start_col = (cmd_col >= COL_LAST) ? COL_LAST : cmd_col;
    next_col  = (col_q == COL_LAST) ? '0 : col_q + 6'd1;
    next_row  = row_q;
    if (col_q == COL_LAST) next_row = (row_q == ROW_LAST) ? '0 : row_q + 4'd1;
  end

  // Next-state and registered-output logic. Outputs are computed one cycle
  // ahead so a PUT write lands in the cycle right after acceptance.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    char_d    = char_q;
    msg_id_d  = msg_id_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          row_d    = start_row;
          col_d    = start_col;
          msg_id_d = cmd_data[1:0];
          idx_d    = '0;
          char_d   = (cmd_op == OP_PUT_DIGIT) ? digit_char(cmd_data[3:0]) : cmd_data;
          case (cmd_op)
            OP_PUT_CHAR, OP_PUT_DIGIT: begin
              if (gate) begin
                wr_en_d   = 1'b1;
                wr_addr_d = tile_addr(start_row, start_col);
                wr_data_d = char_d;
                state_d   = S_FIN;
              end else begin
                state_d   = S_PUT;
              end
            end
            OP_PUT_STR: state_d = S_STR_FETCH;
            OP_CLEAR: begin
              row_d   = '0;
              col_d   = '0;
              state_d = S_CLR;
            end
            default: state_d = S_FIN;
          endcase
        end
      end
      S_PUT: begin
        if (gate) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tile_addr(row_q, col_q);
          wr_data_d = char_q;
          state_d   = S_FIN;
        end
      end
      S_STR_FETCH: state_d = S_STR_WAIT;
      S_STR_WAIT: begin
        if (rom_data == ASCII_BLANK || idx_q == IDX_LIMIT) state_d = S_FIN;
        else                                                state_d = S_STR_WR;
      end
      S_STR_WR: begin
        if (gate) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tile_addr(row_q, col_q);
          wr_data_d = rom_data;
          row_d     = next_row;
          col_d     = next_col;
          idx_d     = idx_q + 5'd1;
          state_d   = S_STR_FETCH;
        end
      end
      S_CLR: begin
        if (gate) begin
          wr_en_d   = 1'b1;
          wr_addr_d = tile_addr(row_q, col_q);
          wr_data_d = ASCII_BLANK;
          row_d     = next_row;
          col_d     = next_col;
          if (row_q == ROW_LAST && col_q == COL_LAST) state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d != S_IDLE) || done_d;
    // Ready stays low for the IDLE cycle that carries the done pulse.
    ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      char_q    <= '0;
      msg_id_q  <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      char_q    <= char_d;
      msg_id_q  <= msg_id_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_text_tile_writer.sv
// Directed bench for text_tile_writer: vector table of single commands plus
// hand sequences for back-to-back, mid-clear reset and vblank-gated clear.
module tb_text_tile_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST_N;

  logic       a_valid, a_ready, a_vblank, a_wr_en, a_busy, a_done;
  logic [2:0] a_op;
  logic [3:0] a_row;
  logic [5:0] a_col;
  logic [6:0] a_data, a_wr_data;
  logic [9:0] a_wr_addr;

  logic       b_valid, b_ready, b_vblank, b_wr_en, b_busy, b_done;
  logic [2:0] b_op;
  logic [3:0] b_row;
  logic [5:0] b_col;
  logic [6:0] b_data, b_wr_data;
  logic [9:0] b_wr_addr;

  text_tile_writer dut (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(a_valid), .cmd_ready(a_ready), .cmd_op(a_op),
    .cmd_row(a_row), .cmd_col(a_col), .cmd_data(a_data), .vblank(a_vblank),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .busy(a_busy), .done(a_done)
  );

  text_tile_writer #(.VBLANK_ONLY(1'b1)) dut_vb (
    .CLK(CLK), .RST_N(RST_N), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_op(b_op),
    .cmd_row(b_row), .cmd_col(b_col), .cmd_data(b_data), .vblank(b_vblank),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .busy(b_busy), .done(b_done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int done_cyc;

  typedef struct {
    logic [2:0] op;
    logic [3:0] row;
    logic [5:0] col;
    logic [6:0] data;
    int n_wr;
    int first_cyc;
    int gap;
    int done_cyc;
    int chk_idx;
    int chk_addr;
    int chk_data;
    int last_addr;
    int last_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // vblank for the gated instance: 10 cycles low, 10 cycles high, repeating.
  initial begin
    b_vblank = 1'b0;
    forever begin
      repeat (10) @(negedge CLK);
      b_vblank = ~b_vblank;
    end
  end

  // Issue one command on the ungated instance and log writes until done.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] row, input logic [5:0] col,
                        input logic [6:0] data, input int max_cyc, input string name);
    int n;
    w_addr.delete(); w_data.delete(); w_cyc.delete();
    done_cyc = -1;
    @(negedge CLK);
    a_valid = 1'b1; a_op = op; a_row = row; a_col = col; a_data = data;
    n = 0;
    while (a_ready !== 1'b1 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    if (a_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s accept: cmd_ready never rose within %0d cycles", name, max_cyc);
      a_valid = 1'b0;
      return;
    end
    @(negedge CLK);
    a_valid = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (a_wr_en === 1'b1) begin
        w_addr.push_back(int'(a_wr_addr));
        w_data.push_back(int'(a_wr_data));
        w_cyc.push_back(c);
      end
      if (a_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      @(negedge CLK);
    end
    if (done_cyc < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s done: no done pulse within %0d cycles", name, max_cyc);
    end
  endtask

  initial begin
    logic [5:0] s_wr, s_done, s_ready, s_busy;
    logic [6:0] s_data1;
    logic [9:0] s_addr1;
    int cnt, last_a, n, bad_t;
    int nwr, bad_gate, bad_addr, bad_data, bad_frozen, r, c;
    logic prev_vb, got_done;
    logic [9:0] prev_addr;
    logic [9:0] exp_a;

    //           op    row    col    data   n  1st gap done idx  chk_a  chk_d  last_a last_d
    vecs[0]  = '{3'd2, 4'd0,  6'd1,  7'd7,  1, 1,  0,  2,   0,   'h001, 'h37,  'h001, 'h37};
    vecs[1]  = '{3'd2, 4'd0,  6'd1,  7'd12, 1, 1,  0,  2,   0,   'h001, 'h3F,  'h001, 'h3F};
    vecs[2]  = '{3'd1, 4'd5,  6'd10, 7'h41, 1, 1,  0,  2,   0,   'h14A, 'h41,  'h14A, 'h41};
    vecs[3]  = '{3'd1, 4'd15, 6'd63, 7'h5A, 1, 1,  0,  2,   0,   'h3A7, 'h5A,  'h3A7, 'h5A};
    vecs[4]  = '{3'd2, 4'd3,  6'd0,  7'd9,  1, 1,  0,  2,   0,   'h0C0, 'h39,  'h0C0, 'h39};
    vecs[5]  = '{3'd2, 4'd0,  6'd50, 7'h7A, 1, 1,  0,  2,   0,   'h027, 'h3F,  'h027, 'h3F};
    vecs[6]  = '{3'd0, 4'd2,  6'd2,  7'h41, 0, 0,  0,  2,   0,   0,     0,     0,     0};
    vecs[7]  = '{3'd6, 4'd1,  6'd1,  7'h41, 0, 0,  0,  2,   0,   0,     0,     0,     0};
    vecs[8]  = '{3'd3, 4'd0,  6'd17, 7'd0,  4, 4,  3,  16,  1,   'h012, 'h4F,  'h014, 'h47};
    vecs[9]  = '{3'd3, 4'd2,  6'd0,  7'd2,  7, 4,  3,  25,  1,   'h081, 'h31,  'h086, 'h53};
    vecs[10] = '{3'd3, 4'd14, 6'd35, 7'd1,  18, 4, 3,  58,  5,   'h000, 'h20,  'h00C, 'h54};
    vecs[11] = '{3'd3, 4'd1,  6'd38, 7'd3,  7, 4,  3,  25,  2,   'h080, 'h20,  'h084, 'h53};

    a_valid = 1'b0; a_op = '0; a_row = '0; a_col = '0; a_data = '0; a_vblank = 1'b0;
    b_valid = 1'b0; b_op = '0; b_row = '0; b_col = '0; b_data = '0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("reset cmd_ready", a_ready, 1);
    chk("reset wr_en", a_wr_en, 0);
    chk("reset wr_addr", a_wr_addr, 0);
    chk("reset wr_data", a_wr_data, 0);
    chk("reset busy", a_busy, 0);
    chk("reset done", a_done, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].row, vecs[i].col, vecs[i].data, 100, $sformatf("v%0d", i));
      chk($sformatf("v%0d write count", i), w_addr.size(), vecs[i].n_wr);
      chk($sformatf("v%0d done cycle", i), done_cyc, vecs[i].done_cyc);
      if (vecs[i].n_wr > 0 && w_addr.size() == vecs[i].n_wr) begin
        bad_t = 0;
        for (int k = 0; k < vecs[i].n_wr; k++)
          if (w_cyc[k] != vecs[i].first_cyc + vecs[i].gap * k) bad_t++;
        chk($sformatf("v%0d write timing errors", i), bad_t, 0);
        chk($sformatf("v%0d addr[%0d]", i, vecs[i].chk_idx), w_addr[vecs[i].chk_idx], vecs[i].chk_addr);
        chk($sformatf("v%0d data[%0d]", i, vecs[i].chk_idx), w_data[vecs[i].chk_idx], vecs[i].chk_data);
        chk($sformatf("v%0d last addr", i), w_addr[vecs[i].n_wr-1], vecs[i].last_addr);
        chk($sformatf("v%0d last data", i), w_data[vecs[i].n_wr-1], vecs[i].last_data);
      end
    end

    // Back-to-back: op 6 held valid while PUT_CHAR is still busy.
    @(negedge CLK);
    a_valid = 1'b1; a_op = 3'd1; a_row = 4'd0; a_col = 6'd2; a_data = 7'h58;
    n = 0;
    while (a_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    chk("b2b first accept ready", a_ready, 1);
    s_addr1 = '0; s_data1 = '0;
    for (int t = 1; t <= 6; t++) begin
      @(negedge CLK);
      if (t == 1) begin a_op = 3'd6; s_addr1 = a_wr_addr; s_data1 = a_wr_data; end
      if (t == 4) a_valid = 1'b0;
      s_wr[t-1] = a_wr_en; s_done[t-1] = a_done; s_ready[t-1] = a_ready; s_busy[t-1] = a_busy;
    end
    chk("b2b wr_en trace", s_wr, 6'b000001);
    chk("b2b done trace", s_done, 6'b010010);
    chk("b2b ready trace", s_ready, 6'b100100);
    chk("b2b busy trace", s_busy, 6'b011011);
    chk("b2b write addr", s_addr1, 10'h002);
    chk("b2b write data", s_data1, 7'h58);

    // Reset in the middle of CLEAR, right after the 100th write.
    @(negedge CLK);
    a_valid = 1'b1; a_op = 3'd4;
    n = 0;
    while (a_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    @(negedge CLK);
    a_valid = 1'b0;
    cnt = 0; last_a = 0;
    for (int k = 0; k < 300 && cnt < 100; k++) begin
      if (a_wr_en === 1'b1) begin cnt++; last_a = int'(a_wr_addr); end
      if (cnt < 100) @(negedge CLK);
    end
    chk("clr writes before reset", cnt, 100);
    chk("clr 100th addr", last_a, 'h093);
    RST_N = 1'b0;
    #1;
    chk("mid-clr reset wr_en", a_wr_en, 0);
    chk("mid-clr reset busy", a_busy, 0);
    chk("mid-clr reset ready", a_ready, 1);
    @(negedge CLK);
    RST_N = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge CLK);
      if (a_wr_en !== 1'b0) cnt++;
    end
    chk("writes after reset", cnt, 0);
    chk("ready after reset", a_ready, 1);

    // Vblank-gated CLEAR on the second instance.
    @(negedge CLK);
    b_valid = 1'b1; b_op = 3'd4;
    n = 0;
    while (b_ready !== 1'b1 && n < 50) begin @(negedge CLK); n++; end
    nwr = 0; bad_gate = 0; bad_addr = 0; bad_data = 0; bad_frozen = 0;
    r = 0; c = 0; got_done = 1'b0; prev_vb = 1'b1; prev_addr = b_wr_addr;
    for (int k = 0; k < 3000 && !got_done; k++) begin
      @(negedge CLK);
      #1;
      b_valid = 1'b0;
      if (b_wr_en === 1'b1) begin
        nwr++;
        if (!prev_vb) bad_gate++;
        exp_a = {4'(r), 6'(c)};
        if (b_wr_addr !== exp_a) bad_addr++;
        if (b_wr_data !== 7'h00) bad_data++;
        c++;
        if (c == 40) begin c = 0; r++; end
      end else if (b_wr_addr !== prev_addr) begin
        bad_frozen++;
      end
      if (b_done === 1'b1) got_done = 1'b1;
      prev_vb = b_vblank;
      prev_addr = b_wr_addr;
    end
    chk("vb clr done seen", got_done, 1);
    chk("vb clr write count", nwr, 600);
    chk("vb clr writes outside vblank", bad_gate, 0);
    chk("vb clr raster addr errors", bad_addr, 0);
    chk("vb clr nonzero data", bad_data, 0);
    chk("vb clr addr moved while idle", bad_frozen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
